// File: rtl/led_pwm_driver.sv
// Eight-channel LED PWM driver with a shared 4-bit brightness and 15-tick period.
// Define LED_PWM_FADE_EN to make levels step by one per period instead of jumping to the target.
module led_pwm_driver #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] led_in,
  input  logic [3:0] brightness,
  input  logic       enable,
  output logic [7:0] led_out,
  output logic       busy
);

  localparam logic [15:0] DivMax = 16'(CLK_DIV - 1);

  logic [15:0]      prescaler_q, prescaler_d;
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic             tick;
  logic             boundary;
  logic [7:0]       led_in_q;
  logic [3:0]       brightness_q;
  logic             enable_q;
  logic [7:0][3:0]  target;
  logic [7:0][3:0]  level_q, level_d;
  logic [7:0]       led_out_q, led_out_d;
  logic             busy_q, busy_d;

  // The PWM counter never reaches 15, so level 15 compares as always-on.
  always_comb begin
    tick        = (prescaler_q == DivMax);
    boundary    = tick && (pwm_cnt_q == 4'd14);
    prescaler_d = tick ? 16'd0 : prescaler_q + 16'd1;
    pwm_cnt_d   = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == 4'd14) ? 4'd0 : pwm_cnt_q + 4'd1;
    end
  end

  always_comb begin
    target    = '0;
    level_d   = level_q;
    led_out_d = '0;
    busy_d    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      target[i] = (led_in_q[i] && enable_q) ? brightness_q : 4'd0;
      if (boundary) begin
`ifdef LED_PWM_FADE_EN
        if (level_q[i] < target[i]) begin
          level_d[i] = level_q[i] + 4'd1;
        end else if (level_q[i] > target[i]) begin
          level_d[i] = level_q[i] - 4'd1;
        end
`else
        level_d[i] = target[i];
`endif
      end
      led_out_d[i] = (pwm_cnt_q < level_q[i]);
      if (level_q[i] != target[i]) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_q  <= '0;
      pwm_cnt_q    <= '0;
      led_in_q     <= '0;
      brightness_q <= '0;
      enable_q     <= 1'b0;
      level_q      <= '0;
      led_out_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      pwm_cnt_q    <= pwm_cnt_d;
      led_in_q     <= led_in;
      brightness_q <= brightness;
      enable_q     <= enable;
      level_q      <= level_d;
      led_out_q    <= led_out_d;
      busy_q       <= busy_d;
    end
  end

  assign led_out = led_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench for led_pwm_driver: a cycle-count reference model queues expected outputs,
// a negedge monitor compares them; directed scenarios are followed by random traffic.
module tb_led_pwm_driver;

  localparam int ClkDiv    = 2;
  localparam int PeriodClk = 15 * ClkDiv;
`ifdef LED_PWM_FADE_EN
  localparam int SettlePeriods = 17;
`else
  localparam int SettlePeriods = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] ledIn = 8'h00;
  logic [3:0] brightness = 4'd0;
  logic       enable = 1'b0;
  logic [7:0] ledOut;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] led;
    logic       busy;
  } expT;

  expT expQ[$];

  int         edgeCount = 0;
  int         modelLevel[8];
  logic [7:0] sLed = 8'h00;
  int         sBr = 0;
  logic       sEn = 1'b0;

  led_pwm_driver #(.CLK_DIV(ClkDiv)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .led_in(ledIn),
    .brightness(brightness),
    .enable(enable),
    .led_out(ledOut),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int modelTarget(int i);
    return (sLed[i] && sEn) ? sBr : 0;
  endfunction

  // Time is tracked as rising edges since reset release; phase and boundaries follow from that count.
  always @(posedge clk) begin : refModel
    expT e;
    int  phase;
    int  t;
    e = '0;
    if (!reset_n) begin
      edgeCount = 0;
      for (int i = 0; i < 8; i++) modelLevel[i] = 0;
      sLed = 8'h00;
      sBr  = 0;
      sEn  = 1'b0;
    end else begin
      phase = (edgeCount / ClkDiv) % 15;
      for (int i = 0; i < 8; i++) begin
        e.led[i] = (phase < modelLevel[i]);
        if (modelLevel[i] != modelTarget(i)) e.busy = 1'b1;
      end
      edgeCount++;
      if (edgeCount % PeriodClk == 0) begin
        for (int i = 0; i < 8; i++) begin
          t = modelTarget(i);
`ifdef LED_PWM_FADE_EN
          if (t > modelLevel[i]) modelLevel[i]++;
          else if (t < modelLevel[i]) modelLevel[i]--;
`else
          modelLevel[i] = t;
`endif
        end
      end
      sLed = ledIn;
      sBr  = int'(brightness);
      sEn  = enable;
    end
    expQ.push_back(e);
  end

  task automatic checkOutput(input expT e);
    checks++;
    if (ledOut !== e.led || busy !== e.busy) begin
      errors++;
      $display("[TB] FAIL scoreboard t=%0t: led_out=%h busy=%b, required led_out=%h busy=%b",
               $time, ledOut, busy, e.led, e.busy);
    end
  endtask

  always @(negedge clk) begin : monitor
    expT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  task automatic checkValue(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got %0d, required %0d", name, $time, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] led, input logic [3:0] br, input logic en);
    @(negedge clk);
    #1;
    ledIn      = led;
    brightness = br;
    enable     = en;
  endtask

  task automatic waitPeriods(input int n);
    repeat (n * PeriodClk) @(negedge clk);
  endtask

  task automatic measureDuty(input string name, input int idx, input int expHigh);
    int highs;
    highs = 0;
    repeat (PeriodClk) begin
      @(negedge clk);
      if (ledOut[idx]) highs++;
    end
    checkValue(name, highs, expHigh);
  endtask

  task automatic waitLevel(input string name, input int idx, input int value);
    int budget;
    budget = 20 * PeriodClk;
    while (modelLevel[idx] != value && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      errors++;
      $display("[TB] FAIL %s: model level %0d, required %0d before timeout", name, modelLevel[idx], value);
    end
  endtask

  task automatic pulseReset(input int cycles);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkValue("resetImmediateLed", int'(ledOut), 0);
    checkValue("resetImmediateBusy", int'(busy), 0);
    repeat (cycles) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    ledIn      = 8'hFF;
    brightness = 4'd15;
    enable     = 1'b1;
    repeat (10) @(negedge clk);
    checkValue("inResetLed", int'(ledOut), 0);
    checkValue("inResetBusy", int'(busy), 0);
    #1;
    ledIn   = 8'h00;
    enable  = 1'b0;
    reset_n = 1'b1;

    applyStimulus(8'h01, 4'd15, 1'b1);
    waitPeriods(SettlePeriods);
    measureDuty("fullOnBit0", 0, PeriodClk);
    measureDuty("fullOnBit7", 7, 0);
    checkValue("fullOnBusy", int'(busy), 0);

    applyStimulus(8'h80, 4'd5, 1'b1);
    waitPeriods(SettlePeriods + 3);
    measureDuty("dutyBit7", 7, 5 * ClkDiv);
    measureDuty("dutyBit0", 0, 0);

    applyStimulus(8'h00, 4'd15, 1'b1);
    waitPeriods(SettlePeriods);
    applyStimulus(8'h01, 4'd15, 1'b1);
`ifdef LED_PWM_FADE_EN
    waitLevel("rampUpTo7", 0, 7);
    applyStimulus(8'h00, 4'd15, 1'b1);
    waitLevel("rampDownTo0", 0, 0);
`else
    waitPeriods(2);
    applyStimulus(8'h00, 4'd15, 1'b1);
`endif
    waitPeriods(2);
    checkValue("rampBusyEnd", int'(busy), 0);

    applyStimulus(8'hFF, 4'd15, 1'b1);
    waitPeriods(SettlePeriods);
    applyStimulus(8'hFF, 4'd15, 1'b0);
    waitPeriods(SettlePeriods);
    measureDuty("disabledBit3", 3, 0);
    applyStimulus(8'hFF, 4'd15, 1'b1);
    waitPeriods(SettlePeriods);
    measureDuty("reenabledBit3", 3, PeriodClk);

    applyStimulus(8'h00, 4'd15, 1'b1);
    waitPeriods(SettlePeriods);
    applyStimulus(8'h01, 4'd15, 1'b1);
`ifdef LED_PWM_FADE_EN
    waitLevel("rampUpTo9", 0, 9);
`else
    waitPeriods(2);
`endif
    pulseReset(5);
    waitPeriods(3);

    for (int iter = 0; iter < 40; iter++) begin
      applyStimulus(8'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(1, 3 * PeriodClk)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) pulseReset($urandom_range(1, 5));
    end
    waitPeriods(SettlePeriods);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter CLK_DIV, default 50, clk cycles per PWM tick; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state is clocked on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 led_in  input  8  LED on/off pattern from the LED PIO output port, synchronous to clk.
REQ-005 brightness  input  4  global duty level, 0 = off, 15 = fully on.
REQ-006 enable  input  1  master enable; 0 forces every target to 0.
REQ-007 led_out  output  8  registered PWM drive to the board LEDs, active-high.
REQ-008 busy  output  1  registered; high while any LED level differs from its target.

Function
REQ-009 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be high for exactly one clk when the prescaler equals CLK_DIV-1.
REQ-010 pwm_cnt (4 bit) SHALL increment on tick over 0..14 and wrap 14->0; value 15 is never reached; one PWM period = 15 ticks.
REQ-011 led_in, brightness and enable SHALL be registered once; target[i] = (led_in_q[i] & enable_q) ? brightness_q : 0.
REQ-012 Per LED, level[i] (4 bit) SHALL update only on the tick where pwm_cnt wraps 14->0 (period boundary); levels never change mid-period.
REQ-013 led_out[i] SHALL be registered as (pwm_cnt < level[i]): level 0 -> constant 0, level 15 -> constant 1, level n -> high n of 15 ticks per period.
REQ-014 Latency: input change -> target updated 1 clk later -> level updated at the next period boundary -> led_out reflects it 1 clk after that.
REQ-015 busy SHALL be registered as OR over i of (level[i] != target[i]).
REQ-016 Input changes arriving on the same clk as a period boundary SHALL take effect at the following boundary (registered target is used).
REQ-017 enable deasserted SHALL drive all targets to 0 without altering led_in_q capture.
REQ-018 Level arithmetic SHALL saturate at 0 and 15; no wrap-around under any input.

Reset
REQ-019 While reset_n is low: prescaler, pwm_cnt, all level[i], led_in_q, brightness_q, enable_q, led_out and busy SHALL be 0.
REQ-020 Reset asserted mid-period or mid-fade SHALL clear state immediately; after release the first tick occurs CLK_DIV clk after the first active edge.

Configuration
REQ-021 Macro LED_PWM_FADE_EN defined: at each period boundary level[i] SHALL step by exactly +1 or -1 toward target[i], or hold if equal (full 0->15 ramp = 15 periods).
REQ-022 LED_PWM_FADE_EN undefined: at each period boundary level[i] SHALL load target[i] directly; busy is then high for at most one period after a target change.

Verification (CLK_DIV=2 in bench; 1 period = 30 clk)
REQ-023 Reset: hold reset_n low with led_in=8'hFF, brightness=15, enable=1 -> led_out=0, busy=0 throughout reset.
REQ-024 Full on, fade off: led_in=8'h01, brightness=15 -> after first boundary led_out[0] constant 1, led_out[7:1] constant 0, busy=0.
REQ-025 Duty, fade off: led_in=8'h80, brightness=5 -> led_out[7] high 10 clk, low 20 clk per 30-clk period.
REQ-026 Fade on: led_in 0->8'h01, brightness=15 -> level[0] rises 1 per period, busy high for 15 periods then 0; reversal led_in=0 mid-ramp at level 7 -> steps down 7,6,...,0.
REQ-027 enable=0 with led_in=8'hFF, brightness=15 -> all led_out 0 from next boundary (fade off) or after ramp (fade on); enable=1 restores.
REQ-028 Reset mid-ramp at level 9 -> led_out=0 and busy=0 immediately; after release ramp restarts from 0.
